nwse_press_sequencer: RTL

Conditions the four raw N/W/S/E push-button inputs and drives them into `lock_fsm` as clean, well-spaced, one-at-a-time presses. Each button is synchronised, debounced and edge-detected; new presses are queued in a pending mask. A fixed-priority sequencer issues them one per slot with a guaranteed high time and a guaranteed low gap. The block sits between the board buttons and the `nwse` input of `lock_fsm`.

---
 rtl/nwse_press_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nwse_press_sequencer.sv
// rtl/nwse_press_sequencer.sv - N/W/S/E button conditioner and one-at-a-time press sequencer
// Optional feature macro: NWSE_DEBOUNCE_EN (per-bit debounce counters; without it stable follows s2 each edge)
module nwse_press_sequencer #(
    parameter int DEB_CYCLES   = 4,
    parameter int PRESS_CYCLES = 2,
    parameter int GAP_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_in,
    output logic [3:0] nwse_out,
    output logic       busy,
    output logic       drop_pulse,
    output logic [7:0] press_count
);

    // One counter width shared by the debounce counters and the slot timer.
    localparam int CNT_MAX0 = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX  = (DEB_CYCLES > CNT_MAX0) ? DEB_CYCLES : CNT_MAX0;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    logic [3:0]    s1_q, s2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    rise;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    prio_onehot, grant_mask;
    logic [3:0]    nwse_q, nwse_d;
    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic [7:0]    count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
        end else begin
            s1_q     <= btn_in;
            s2_q     <= s1_q;
            stable_q <= stable_d;
        end
    end

`ifdef NWSE_DEBOUNCE_EN
    logic [3:0][CW-1:0] deb_q, deb_d;

    // A new level is accepted only after DEB_CYCLES consecutive mismatching cycles.
    always_comb begin
        deb_d    = '0;
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (deb_q[i] == CW'(DEB_CYCLES - 1)) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end
`else
    assign stable_d = s2_q;
`endif

    assign rise = stable_d & ~stable_q;

    always_comb begin
        prio_onehot = 4'b0000;
        if (pending_q[3]) begin
            prio_onehot = 4'b1000;
        end else if (pending_q[2]) begin
            prio_onehot = 4'b0100;
        end else if (pending_q[1]) begin
            prio_onehot = 4'b0010;
        end else if (pending_q[0]) begin
            prio_onehot = 4'b0001;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        nwse_d     = nwse_q;
        count_d    = count_q;
        grant_mask = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != 4'b0000) begin
                    grant_mask = prio_onehot;
                    nwse_d     = prio_onehot;
                    count_d    = count_q + 8'd1;
                    timer_d    = '0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (timer_q == CW'(PRESS_CYCLES - 1)) begin
                    nwse_d  = 4'b0000;
                    timer_d = '0;
                    state_d = ST_GAP;
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == CW'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            default: begin
                nwse_d  = 4'b0000;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        // A rise on the edge that grants the same bit re-arms it instead of dropping it.
        pending_d = (pending_q & ~grant_mask) | rise;
        drop_d    = |(rise & pending_q & ~grant_mask);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            nwse_q    <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            nwse_q    <= nwse_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
        end
    end

    assign nwse_out    = nwse_q;
    assign busy        = busy_q;
    assign drop_pulse  = drop_q;
    assign press_count = count_q;

endmodule
